// File: rtl/jtmx5k_sndcmd_if.sv
// Sound command link bundle: main-CPU write side, sound-CPU ack and the latch/IRQ it sees.
// The DUT takes the slave modport; the master modport is for whatever drives the CPU side.
interface jtmx5k_sndcmd_if #(
    parameter int AW = 2
);
    logic          wr;
    logic [7:0]    din;
    logic          flush;
    logic          snd_ack;
    logic [7:0]    snd_latch;
    logic          snd_irq;
    logic [AW:0]   pending;
    logic          full;
    logic          busy;
    logic          ovf;

    modport master (
        output wr, din, flush, snd_ack,
        input  snd_latch, snd_irq, pending, full, busy, ovf
    );

    modport slave (
        input  wr, din, flush, snd_ack,
        output snd_latch, snd_irq, pending, full, busy, ovf
    );
endinterface

// File: rtl/jtmx5k_sndcmd.sv
// Main-CPU side of the sound command link: queues command bytes and hands them one at a
// time to the sound CPU as a latch value plus a fixed-length IRQ pulse.
module jtmx5k_sndcmd #(
    parameter int AW     = 2,
    parameter int IRQLEN = 8,
    parameter int TOW    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    jtmx5k_sndcmd_if.slave    bus
);
    localparam int              DEPTH    = 2**AW;
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [TOW-1:0]  TO_MAX   = {TOW{1'b1}};
    localparam logic [7:0]      IRQ_INIT = 8'(IRQLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_IRQ  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_pop;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [AW:0]     r_count;
    logic            r_ovf;
    logic [7:0]      r_latch;
    logic            r_irq;
    logic [7:0]      r_irqcnt;
    logic [TOW-1:0]  r_tocnt;
    logic            r_ack_seen;

    logic            w_full;
    logic            w_push;
    logic            w_drop;
    logic            w_irq_done;

    assign w_full     = (r_count == CNT_FULL);
    assign w_push     = bus.wr & ~bus.flush & ~w_full;
    assign w_drop     = bus.wr & ~bus.flush & w_full;
    assign w_irq_done = (r_irqcnt == 8'd0);

    // State register; flush outranks the normal transition.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else if (bus.flush) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; an ack arriving on the last IRQ cycle still skips WAIT.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != CNT_ZERO) begin
                    w_next = ST_LOAD;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_pop  = (r_count != CNT_ZERO);
                w_next = ST_IRQ;
            end
            ST_IRQ: begin
                if (w_irq_done) begin
                    if (r_ack_seen || bus.snd_ack) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_next = ST_WAIT;
                    end
                end else begin
                    w_next = ST_IRQ;
                end
            end
            ST_WAIT: begin
                if (bus.snd_ack || (r_tocnt == TO_MAX)) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // FIFO storage; no reset needed, validity is tracked by r_count.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_mem[r_wp] <= bus.din;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.flush) begin
            r_wp    <= {AW{1'b0}};
            r_rp    <= {AW{1'b0}};
            r_count <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.flush) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    // Latch, IRQ pulse and the two counters; flush drops the pulse but keeps the latch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_latch    <= 8'd0;
            r_irq      <= 1'b0;
            r_irqcnt   <= 8'd0;
            r_tocnt    <= {TOW{1'b0}};
            r_ack_seen <= 1'b0;
        end else if (bus.flush) begin
            r_irq      <= 1'b0;
            r_irqcnt   <= 8'd0;
            r_tocnt    <= {TOW{1'b0}};
            r_ack_seen <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack_seen <= 1'b0;
                end
                ST_LOAD: begin
                    r_latch    <= r_mem[r_rp];
                    r_irq      <= 1'b1;
                    r_irqcnt   <= IRQ_INIT;
                    r_ack_seen <= r_ack_seen | bus.snd_ack;
                end
                ST_IRQ: begin
                    r_ack_seen <= r_ack_seen | bus.snd_ack;
                    if (w_irq_done) begin
                        r_irq   <= 1'b0;
                        r_tocnt <= {TOW{1'b0}};
                    end else begin
                        r_irqcnt <= r_irqcnt - 8'd1;
                    end
                end
                ST_WAIT: begin
                    r_tocnt <= r_tocnt + TOW'(1);
                end
                default: begin
                    r_irq <= 1'b0;
                end
            endcase
        end
    end

    assign bus.snd_latch = r_latch;
    assign bus.snd_irq   = r_irq;
    assign bus.pending   = r_count;
    assign bus.full      = w_full;
    assign bus.busy      = (r_state != ST_IDLE) || (r_count != CNT_ZERO);
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_jtmx5k_sndcmd.sv
// Directed self-checking bench for jtmx5k_sndcmd (AW=2, IRQLEN=4, TOW=4).
module tb_jtmx5k_sndcmd;
    localparam int AW     = 2;
    localparam int IRQLEN = 4;
    localparam int TOW    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jtmx5k_sndcmd_if #(.AW(AW)) bus ();

    jtmx5k_sndcmd #(.AW(AW), .IRQLEN(IRQLEN), .TOW(TOW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic write(input logic [7:0] d);
        bus.wr  = 1'b1;
        bus.din = d;
        step();
        bus.wr  = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.snd_ack = 1'b1;
        step();
        bus.snd_ack = 1'b0;
    endtask

    task automatic wait_irq(input logic lvl, input string tag);
        int n;
        n = 0;
        while (bus.snd_irq !== lvl && n < 40) begin
            step();
            n++;
        end
        check(tag, {31'd0, bus.snd_irq}, {31'd0, lvl});
    endtask

    task automatic deliver(input logic [7:0] exp, input int dly, input string tag);
        wait_irq(1'b1, {tag, "_rise"});
        check({tag, "_latch"}, {24'd0, bus.snd_latch}, {24'd0, exp});
        wait_irq(1'b0, {tag, "_fall"});
        repeat (dly) step();
        ack_pulse();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst         = 1'b1;
        bus.wr      = 1'b0;
        bus.din     = 8'h00;
        bus.flush   = 1'b0;
        bus.snd_ack = 1'b0;

        // 1: reset values and single-command latency
        do_reset();
        check("rst_latch",   {24'd0, bus.snd_latch}, 32'h0);
        check("rst_irq",     {31'd0, bus.snd_irq},   32'h0);
        check("rst_pending", {29'd0, bus.pending},   32'h0);
        check("rst_ovf",     {31'd0, bus.ovf},       32'h0);
        check("rst_full",    {31'd0, bus.full},      32'h0);
        check("rst_busy",    {31'd0, bus.busy},      32'h0);
        write(8'h5A);
        check("t1_pend_n",   {29'd0, bus.pending},   32'h1);
        check("t1_irq_n",    {31'd0, bus.snd_irq},   32'h0);
        step();
        check("t1_irq_n1",   {31'd0, bus.snd_irq},   32'h0);
        check("t1_latch_n1", {24'd0, bus.snd_latch}, 32'h0);
        step();
        check("t1_irq_n2",   {31'd0, bus.snd_irq},   32'h1);
        check("t1_latch_n2", {24'd0, bus.snd_latch}, 32'h5A);
        check("t1_pend_n2",  {29'd0, bus.pending},   32'h0);
        repeat (IRQLEN - 1) step();
        check("t1_irq_last", {31'd0, bus.snd_irq},   32'h1);
        step();
        check("t1_irq_fall", {31'd0, bus.snd_irq},   32'h0);
        check("t1_busy_wait",{31'd0, bus.busy},      32'h1);
        check("t1_latch_hold",{24'd0, bus.snd_latch},32'h5A);
        ack_pulse();
        check("t1_busy_done",{31'd0, bus.busy},      32'h0);

        // 2: four back-to-back writes, ack 10 cycles after each fall (inside TOW=4 window)
        write(8'h01); write(8'h02); write(8'h03); write(8'h04);
        check("t2_pend_after_wr", {29'd0, bus.pending}, 32'h3);
        for (int k = 1; k <= 4; k++) begin
            deliver(8'(k), 10, $sformatf("t2_b%0d", k));
            check($sformatf("t2_pend_b%0d", k), {29'd0, bus.pending}, 32'(4 - k));
        end
        check("t2_busy_end", {31'd0, bus.busy}, 32'h0);

        // 3: overflow while the first command waits for its ack
        do_reset();
        write(8'h11);
        wait_irq(1'b1, "t3_rise0");
        wait_irq(1'b0, "t3_fall0");
        for (int k = 0; k < 6; k++) write(8'h12 + 8'(k));
        check("t3_pend", {29'd0, bus.pending}, 32'h4);
        check("t3_full", {31'd0, bus.full},    32'h1);
        check("t3_ovf",  {31'd0, bus.ovf},     32'h1);
        ack_pulse();
        for (int k = 0; k < 4; k++) deliver(8'h12 + 8'(k), 2, $sformatf("t3_b%0d", k));
        check("t3_pend_end", {29'd0, bus.pending}, 32'h0);
        check("t3_ovf_sticky", {31'd0, bus.ovf},   32'h1);
        step();
        check("t3_no_extra_irq", {31'd0, bus.snd_irq}, 32'h0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("t3_ovf_flushed", {31'd0, bus.ovf}, 32'h0);

        // 4: timeout with no ack, then an ack inside the IRQ window skips WAIT
        do_reset();
        write(8'hA1);
        write(8'hA2);
        wait_irq(1'b1, "t4_rise1");
        check("t4_latch1", {24'd0, bus.snd_latch}, 32'hA1);
        wait_irq(1'b0, "t4_fall1");
        check("t4_busy_wait", {31'd0, bus.busy}, 32'h1);
        n = 0;
        while (bus.snd_irq !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        check("t4_timeout_gap", 32'(n), 32'((2**TOW - 1) + 3));
        check("t4_latch2", {24'd0, bus.snd_latch}, 32'hA2);
        ack_pulse();
        wait_irq(1'b0, "t4_fall2");
        check("t4_no_wait", {31'd0, bus.busy}, 32'h0);

        // 5: flush during IRQ with two pending, then wr+flush on the same edge
        do_reset();
        write(8'hB1); write(8'hB2); write(8'hB3);
        check("t5_irq",   {31'd0, bus.snd_irq},   32'h1);
        check("t5_pend",  {29'd0, bus.pending},   32'h2);
        check("t5_latch", {24'd0, bus.snd_latch}, 32'hB1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("t5_irq_fl",   {31'd0, bus.snd_irq},   32'h0);
        check("t5_pend_fl",  {29'd0, bus.pending},   32'h0);
        check("t5_ovf_fl",   {31'd0, bus.ovf},       32'h0);
        check("t5_latch_fl", {24'd0, bus.snd_latch}, 32'hB1);
        check("t5_busy_fl",  {31'd0, bus.busy},      32'h0);
        bus.wr    = 1'b1;
        bus.din   = 8'hB4;
        bus.flush = 1'b1;
        step();
        bus.wr    = 1'b0;
        bus.flush = 1'b0;
        check("t5_wrfl_pend", {29'd0, bus.pending}, 32'h0);
        repeat (3) step();
        check("t5_wrfl_irq",   {31'd0, bus.snd_irq},   32'h0);
        check("t5_wrfl_latch", {24'd0, bus.snd_latch}, 32'hB1);

        // 6: push coinciding with the LOAD pop, then reset while in WAIT
        do_reset();
        write(8'hC1);
        step();
        write(8'hC2);
        check("t6_pend",  {29'd0, bus.pending},   32'h1);
        check("t6_latch", {24'd0, bus.snd_latch}, 32'hC1);
        ack_pulse();
        wait_irq(1'b0, "t6_fall1");
        wait_irq(1'b1, "t6_rise2");
        check("t6_latch2", {24'd0, bus.snd_latch}, 32'hC2);
        check("t6_pend2",  {29'd0, bus.pending},   32'h0);
        wait_irq(1'b0, "t6_fall2");
        write(8'hC3);
        check("t6_busy_wait", {31'd0, bus.busy}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_latch",   {24'd0, bus.snd_latch}, 32'h0);
        check("t6_rst_irq",     {31'd0, bus.snd_irq},   32'h0);
        check("t6_rst_pending", {29'd0, bus.pending},   32'h0);
        check("t6_rst_ovf",     {31'd0, bus.ovf},       32'h0);
        check("t6_rst_full",    {31'd0, bus.full},      32'h0);
        check("t6_rst_busy",    {31'd0, bus.busy},      32'h0);
        repeat (3) step();
        check("t6_rst_quiet",   {31'd0, bus.snd_irq},   32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
